lock_access_controller: RTL and testbench

Sequencing and arbitration controller in front of the smart lock actuator path. It collects multi-digit keypad entries and checks them against a main code and an optional temporary code. It arbitrates keypad, remote and auto-relock requests into single-cycle lock/unlock commands, and enforces a failed-attempt lockout. It sits between the user-input front ends and the smart lock block, and is the only source of that block's lock/unlock requests.

---
 rtl/home_pkg.sv | 19 +
 rtl/lock_code_entry.sv | 60 ++++++
 rtl/lock_access_controller.sv | 136 +++++++++++++
 tb/tb_lock_access_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/home_pkg.sv
// Shared types for the lock access path: controller states, keypad digit width
// and a saturating increment helper for the failed-attempt counter.
package home_pkg;
  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } lock_state_e;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + 3'd1;
    end
  endfunction
endpackage

// File: rtl/lock_code_entry.sv
// Keypad entry buffer: keeps the last DIGITS digits and a saturating count, and
// flags match/mismatch on key_enter against the main and temporary codes.
module lock_code_entry import home_pkg::*; #(
  parameter int DIGITS = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] MAIN_CODE = 16'hA5A5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold_clear,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_digit,
  input  logic                        key_enter,
  input  logic [DIGITS*DIGIT_W-1:0]   temp_code,
  input  logic                        temp_code_en,
  output logic                        code_match,
  output logic                        code_mismatch,
  output logic                        has_content
);
  localparam int CODE_W   = DIGITS * DIGIT_W;
  localparam int CNT_BITS = $clog2(DIGITS + 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DIGITS);

  logic [CODE_W-1:0]   buf_r;
  logic [CODE_W-1:0]   buf_s;
  logic [CNT_BITS-1:0] cnt_r;
  logic [CNT_BITS-1:0] cnt_s;
  logic                hit_s;

  // Same-cycle digit is folded in before the entry is evaluated.
  always_comb begin
    buf_s = buf_r;
    cnt_s = cnt_r;
    if (key_valid) begin
      buf_s = (buf_r << DIGIT_W) | CODE_W'(key_digit);
      if (cnt_r != CNT_FULL) begin
        cnt_s = cnt_r + CNT_BITS'(1);
      end else begin
        cnt_s = cnt_r;
      end
    end else begin
      buf_s = buf_r;
    end
    hit_s = (cnt_s == CNT_FULL) &&
            ((buf_s == MAIN_CODE) || (temp_code_en && (buf_s == temp_code)));
    code_match    = key_enter && !hold_clear && hit_s;
    code_mismatch = key_enter && !hold_clear && !hit_s;
    has_content   = !hold_clear && (cnt_s != {CNT_BITS{1'b0}});
  end

  // Entry storage; every enter, and any lockout cycle, discards the entry.
  always_ff @(posedge clk) begin
    if (!rst || hold_clear || key_enter) begin
      buf_r <= {CODE_W{1'b0}};
      cnt_r <= {CNT_BITS{1'b0}};
    end else begin
      buf_r <= buf_s;
      cnt_r <= cnt_s;
    end
  end
endmodule

// File: rtl/lock_access_controller.sv
// Lock/unlock arbitration: keypad, remote and auto-relock requests become
// single-cycle actuator commands, with a failed-attempt lockout.
module lock_access_controller import home_pkg::*; #(
  parameter int DIGITS = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] MAIN_CODE = 16'hA5A5,
  parameter int MAX_FAILS = 3,
  parameter int RELOCK_CYCLES = 1000,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_digit,
  input  logic                        key_enter,
  input  logic                        remote_unlock,
  input  logic                        remote_lock,
  input  logic [DIGITS*DIGIT_W-1:0]   temp_code,
  input  logic                        temp_code_en,
  output logic                        unlock_cmd,
  output logic                        lock_cmd,
  output logic                        locked,
  output logic                        lockout,
  output logic [2:0]                  fail_cnt
);
  localparam logic [2:0]       FAIL_LIM     = 3'(MAX_FAILS);
  localparam logic [CNT_W-1:0] RELOCK_LAST  = CNT_W'(RELOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  lock_state_e       state_r, state_s;
  logic [CNT_W-1:0]  timer_r, timer_s;
  logic [2:0]        fail_r, fail_s;
  logic              unlock_s, lock_s;
  logic              unlock_cmd_r, lock_cmd_r, locked_r, lockout_r;
  logic              code_match_s, code_mismatch_s, has_content_s;
  logic              remote_unlock_s;

  lock_code_entry #(.DIGITS(DIGITS), .MAIN_CODE(MAIN_CODE)) u_entry (
    .clk           (clk),
    .rst           (rst),
    .hold_clear    (state_r == LOCKOUT),
    .key_valid     (key_valid),
    .key_digit     (key_digit),
    .key_enter     (key_enter),
    .temp_code     (temp_code),
    .temp_code_en  (temp_code_en),
    .code_match    (code_match_s),
    .code_mismatch (code_mismatch_s),
    .has_content   (has_content_s)
  );

  // Both remote lines high counts as a lock request.
  assign remote_unlock_s = remote_unlock && !remote_lock;

  // Next-state arbitration: remote_lock > remote_unlock > keypad > timer.
  always_comb begin
    state_s  = state_r;
    fail_s   = fail_r;
    unlock_s = 1'b0;
    lock_s   = 1'b0;
    case (state_r)
      LOCKED: begin
        if (remote_unlock_s || code_match_s) begin
          state_s  = UNLOCKED;
          unlock_s = 1'b1;
          fail_s   = 3'd0;
        end else if (code_mismatch_s) begin
          fail_s = sat_inc3(fail_r, FAIL_LIM);
          if (fail_s == FAIL_LIM) begin
            state_s = LOCKOUT;
          end else begin
            state_s = LOCKED;
          end
        end else begin
          state_s = LOCKED;
        end
      end
      UNLOCKED: begin
        if (remote_lock || (key_enter && has_content_s) || (timer_r >= RELOCK_LAST)) begin
          state_s = LOCKED;
          lock_s  = 1'b1;
        end else begin
          state_s = UNLOCKED;
        end
      end
      LOCKOUT: begin
        if (remote_unlock_s) begin
          state_s  = UNLOCKED;
          unlock_s = 1'b1;
          fail_s   = 3'd0;
        end else if (timer_r >= LOCKOUT_LAST) begin
          state_s = LOCKED;
          fail_s  = 3'd0;
        end else begin
          state_s = LOCKOUT;
        end
      end
      default: begin
        state_s = LOCKED;
        fail_s  = fail_r;
      end
    endcase
    if ((state_s != state_r) || (state_r == LOCKED)) begin
      timer_s = {CNT_W{1'b0}};
    end else begin
      timer_s = timer_r + CNT_W'(1);
    end
  end

  // State, timer, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= LOCKED;
      timer_r      <= {CNT_W{1'b0}};
      fail_r       <= 3'd0;
      unlock_cmd_r <= 1'b0;
      lock_cmd_r   <= 1'b0;
      locked_r     <= 1'b1;
      lockout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      fail_r       <= fail_s;
      unlock_cmd_r <= unlock_s;
      lock_cmd_r   <= lock_s;
      locked_r     <= (state_s != UNLOCKED);
      lockout_r    <= (state_s == LOCKOUT);
    end
  end

  assign unlock_cmd = unlock_cmd_r;
  assign lock_cmd   = lock_cmd_r;
  assign locked     = locked_r;
  assign lockout    = lockout_r;
  assign fail_cnt   = fail_r;
endmodule

// File: tb/tb_lock_access_controller.sv
// Scoreboard bench: a per-cycle reference model pushes expected outputs; a
// monitor pops and compares them one time step after every rising edge.
module tb_lock_access_controller;
  localparam int DIGITS = 4;
  localparam logic [15:0] MAIN = 16'hA5A5;
  localparam int MAXF = 3;
  localparam int RELOCK = 8;
  localparam int LOCKOUT_C = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_valid = 1'b0, key_enter = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic remote_unlock = 1'b0, remote_lock = 1'b0;
  logic [15:0] temp_code = 16'h0000;
  logic temp_code_en = 1'b0;
  logic unlock_cmd, lock_cmd, locked, lockout;
  logic [2:0] fail_cnt;

  lock_access_controller #(
    .DIGITS(DIGITS), .MAIN_CODE(MAIN), .MAX_FAILS(MAXF),
    .RELOCK_CYCLES(RELOCK), .LOCKOUT_CYCLES(LOCKOUT_C), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .remote_unlock(remote_unlock), .remote_lock(remote_lock),
    .temp_code(temp_code), .temp_code_en(temp_code_en),
    .unlock_cmd(unlock_cmd), .lock_cmd(lock_cmd), .locked(locked),
    .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       u;
    logic       l;
    logic       lk;
    logic       lo;
    logic [2:0] f;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: 0=locked, 1=unlocked, 2=lockout; dwell = edges since entry.
  int m_state = 0;
  int m_dwell = 0;
  int m_fail  = 0;
  logic [3:0] m_digits[$];

  task automatic model_reset();
    exp_t e;
    m_state = 0;
    m_dwell = 0;
    m_fail  = 0;
    m_digits.delete();
    e = '{u: 1'b0, l: 1'b0, lk: 1'b1, lo: 1'b0, f: 3'd0};
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kd, input bit ke,
                            input bit ru, input bit rl);
    int nxt;
    bit u, l, hit, content;
    logic [15:0] val;
    exp_t e;
    nxt = m_state;
    u = 1'b0;
    l = 1'b0;
    if (m_state != 2 && kv) begin
      m_digits.push_back(kd);
      if (m_digits.size() > DIGITS) void'(m_digits.pop_front());
    end
    val = 16'h0000;
    foreach (m_digits[i]) val = (val << 4) | 16'(m_digits[i]);
    hit = (m_digits.size() == DIGITS) &&
          ((val == MAIN) || (temp_code_en && (val == temp_code)));
    content = (m_digits.size() > 0);
    if (ke || m_state == 2) m_digits.delete();
    case (m_state)
      0: begin
        if (ru && !rl) begin nxt = 1; u = 1'b1; m_fail = 0; end
        else if (ke) begin
          if (hit) begin nxt = 1; u = 1'b1; m_fail = 0; end
          else begin
            m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
            if (m_fail == MAXF) nxt = 2;
          end
        end
      end
      1: begin
        if (rl || (ke && content) || (m_dwell == RELOCK - 1)) begin nxt = 0; l = 1'b1; end
      end
      default: begin
        if (ru && !rl) begin nxt = 1; u = 1'b1; m_fail = 0; end
        else if (m_dwell == LOCKOUT_C - 1) begin nxt = 0; m_fail = 0; end
      end
    endcase
    m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
    m_state = nxt;
    e = '{u: u, l: l, lk: (nxt != 1), lo: (nxt == 2), f: 3'(m_fail)};
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit kv, input logic [3:0] kd, input bit ke,
                      input bit ru, input bit rl);
    @(negedge clk);
    rst = 1'b1;
    key_valid = kv; key_digit = kd; key_enter = ke;
    remote_unlock = ru; remote_lock = rl;
    model_step(kv, kd, ke, ru, rl);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      key_valid = 1'b0; key_enter = 1'b0; remote_unlock = 1'b0; remote_lock = 1'b0;
      model_reset();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Keys the n low digits of code (most significant first); optionally enter with the last digit.
  task automatic keys(input logic [31:0] code, input int n, input bit do_enter, input bit fuse);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, code[4*(n-1-i) +: 4], (fuse && do_enter && i == n - 1), 1'b0, 1'b0);
    end
    if (do_enter && !(fuse && n > 0)) tick(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare every registered output against the scoreboard head.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{u: unlock_cmd, l: lock_cmd, lk: locked, lo: lockout, f: fail_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual u=%b l=%b locked=%b lockout=%b fail=%0d required u=%b l=%b locked=%b lockout=%b fail=%0d",
                 cyc, a.u, a.l, a.lk, a.lo, a.f, e.u, e.l, e.lk, e.lo, e.f);
      end
    end
  end

  initial begin
    do_reset(2);
    idle(1);
    // Main code, then auto relock
    keys(32'hA5A5, 4, 1'b1, 1'b0);
    idle(10);
    // Temporary code enabled, then disabled
    temp_code = 16'h1234; temp_code_en = 1'b1;
    keys(32'h1234, 4, 1'b1, 1'b0);
    idle(10);
    temp_code_en = 1'b0;
    keys(32'h1234, 4, 1'b1, 1'b0);
    idle(2);
    // Lockout, ignored correct entry, expiry
    keys(32'hFFFF, 4, 1'b1, 1'b0);
    keys(32'hFFFF, 4, 1'b1, 1'b0);
    keys(32'hFFFF, 4, 1'b1, 1'b0);
    keys(32'hA5A5, 4, 1'b1, 1'b0);
    idle(14);
    // Lockout override by remote, then simultaneous remotes while unlocked
    keys(32'hFFFF, 4, 1'b1, 1'b0);
    keys(32'hFFFF, 4, 1'b1, 1'b0);
    keys(32'hFFFF, 4, 1'b1, 1'b0);
    idle(3);
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    tick(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    idle(2);
    // Short entry, six-digit entry, digit fused with enter
    keys(32'h00A5, 2, 1'b1, 1'b0);
    keys(32'h0000A5A5, 6, 1'b1, 1'b0);
    idle(9);
    keys(32'hA5A5, 4, 1'b1, 1'b1);
    idle(3);
    // Reset mid-timer and mid-entry
    do_reset(1);
    keys(32'h0A5A, 3, 1'b0, 1'b0);
    do_reset(2);
    keys(32'h0005, 1, 1'b1, 1'b0);
    keys(32'hA5A5, 4, 1'b1, 1'b0);
    idle(9);
    // Randomised traffic
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) temp_code_en = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) temp_code = 16'($urandom);
      if (r < 25) keys({16'h0, MAIN}, 4, 1'b1, $urandom_range(0, 1));
      else if (r < 35) keys({16'h0, temp_code}, 4, 1'b1, $urandom_range(0, 1));
      else if (r < 55) keys($urandom, $urandom_range(1, 6), $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 70) tick(1'b0, 4'd0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
      else if (r < 72) do_reset(1);
      else if (r < 80) tick($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 1),
                            $urandom_range(0, 1), $urandom_range(0, 1));
      else idle($urandom_range(1, 12));
    end
    idle(2);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
